// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: widths, opcodes,
// control FSM states and small opcode-classification helpers.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 4;

    // Opcodes are shared with the ALU; ALU-class opcodes double as alu_sel codes.
    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_NOR  = 4'h3;
    localparam logic [OP_W-1:0] OP_MOVR = 4'h4;
    localparam logic [OP_W-1:0] OP_MOVA = 4'h5;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h6;
    localparam logic [OP_W-1:0] OP_JC   = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h9;
    localparam logic [OP_W-1:0] OP_HALT = 4'hA;
    localparam logic [OP_W-1:0] OP_SHL  = 4'hB;
    localparam logic [OP_W-1:0] OP_SHR  = 4'hC;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPER,
        EXEC,
        HALT
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] n;
    } instr_t;

    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        return (op == OP_JZ) || (op == OP_JC) || (op == OP_JMP) || (op == OP_LDI);
    endfunction

    function automatic logic sets_flags(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
               (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic writes_acc(input logic [OP_W-1:0] op);
        return sets_flags(op) || (op == OP_MOVR) || (op == OP_LDI);
    endfunction

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_SHR;
    endfunction

    // Non-ALU instructions park the ALU on NOP.
    function automatic logic [OP_W-1:0] alu_code(input logic [OP_W-1:0] op);
        return (writes_acc(op) && (op != OP_LDI)) ? op : OP_NOP;
    endfunction

endpackage

// File: rtl/cpu_pc.sv
// Program counter with +1/+2/branch-target selection; advances only when en is high.
module cpu_pc
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] target,
    input  logic            flag_z,
    input  logic            flag_c,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc_c,
    output logic [PC_W-1:0] pc_nxt_c
);

    logic taken_c;

    // Conditional jumps test the flags latched by the last flag-setting op.
    always_comb begin
        taken_c = 1'b0;
        case (op)
            OP_JMP:  taken_c = 1'b1;
            OP_JZ:   taken_c = flag_z;
            OP_JC:   taken_c = flag_c;
            default: taken_c = 1'b0;
        endcase
    end

    always_comb begin
        pc_inc_c = pc + PC_W'(1);
        if (taken_c) begin
            pc_nxt_c = target;
        end else if (is_two_byte(op)) begin
            pc_nxt_c = pc + PC_W'(2);
        end else begin
            pc_nxt_c = pc_inc_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            pc <= pc_nxt_c;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator CPU.
// All outputs are registered; EXEC strobes are high exactly while the FSM is in EXEC.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    output logic [OP_W-1:0]   alu_sel,
    output logic              acc_we,
    output logic              acc_src,
    output logic              reg_we,
    output logic [REG_W-1:0]  reg_addr,
    output logic [DATA_W-1:0] imm,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted,
    output logic              illegal
);

    state_t            state;
    state_t            next_state;
    logic [OP_W-1:0]   op_q;
    instr_t            rd_c;
    logic              pc_en_c;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_inc_c;
    logic [PC_W-1:0]   pc_nxt_c;

    logic              req_d;
    logic [PC_W-1:0]   addr_d;
    logic [OP_W-1:0]   op_d;
    logic [OP_W-1:0]   alu_sel_d;
    logic [REG_W-1:0]  reg_addr_d;
    logic [DATA_W-1:0] imm_d;
    logic              acc_we_d;
    logic              acc_src_d;
    logic              reg_we_d;
    logic              illegal_d;
    logic              halted_d;
    logic              flag_z_d;
    logic              flag_c_d;

    cpu_pc u_pc (
        .clk      (clk),
        .rst      (rst),
        .en       (pc_en_c),
        .op       (op_q),
        .target   (imm),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .pc       (pc),
        .pc_inc_c (pc_inc_c),
        .pc_nxt_c (pc_nxt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        next_state = state;
        req_d      = 1'b0;
        addr_d     = mem_addr;
        op_d       = op_q;
        alu_sel_d  = alu_sel;
        reg_addr_d = reg_addr;
        imm_d      = imm;
        acc_we_d   = 1'b0;
        acc_src_d  = 1'b0;
        reg_we_d   = 1'b0;
        illegal_d  = 1'b0;
        halted_d   = halted;
        flag_z_d   = flag_z;
        flag_c_d   = flag_c;
        pc_en_c    = 1'b0;
        rd_c       = instr_t'(mem_rdata);

        case (state)
            FETCH: begin
                // Gating with mem_req drops stale rvalid from an aborted request.
                req_d  = 1'b1;
                addr_d = pc;
                if (mem_req && mem_rvalid) begin
                    next_state = DECODE;
                    req_d      = 1'b0;
                    op_d       = rd_c.op;
                    alu_sel_d  = alu_code(rd_c.op);
                    reg_addr_d = rd_c.n;
                end
            end
            DECODE: begin
                if (is_two_byte(op_q)) begin
                    next_state = OPER;
                    req_d      = 1'b1;
                    addr_d     = pc_inc_c;
                end else begin
                    next_state = EXEC;
                end
            end
            OPER: begin
                req_d = 1'b1;
                if (mem_req && mem_rvalid) begin
                    next_state = EXEC;
                    req_d      = 1'b0;
                    imm_d      = mem_rdata;
                end
            end
            EXEC: begin
                pc_en_c = 1'b1;
                if (op_q == OP_HALT) begin
                    next_state = HALT;
                    halted_d   = 1'b1;
                end else begin
                    next_state = FETCH;
                    req_d      = 1'b1;
                    addr_d     = pc_nxt_c;
                end
                if (sets_flags(op_q)) begin
                    flag_z_d = alu_z;
                    flag_c_d = alu_c;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // Strobes are registered on entry so they cover exactly the EXEC cycle.
        if (next_state == EXEC) begin
            acc_we_d  = writes_acc(op_q);
            acc_src_d = (op_q == OP_LDI);
            reg_we_d  = (op_q == OP_MOVA);
            illegal_d = is_illegal(op_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            op_q     <= OP_NOP;
            alu_sel  <= OP_NOP;
            reg_addr <= '0;
            imm      <= '0;
            acc_we   <= 1'b0;
            acc_src  <= 1'b0;
            reg_we   <= 1'b0;
            illegal  <= 1'b0;
            halted   <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            mem_req  <= req_d;
            mem_addr <= addr_d;
            op_q     <= op_d;
            alu_sel  <= alu_sel_d;
            reg_addr <= reg_addr_d;
            imm      <= imm_d;
            acc_we   <= acc_we_d;
            acc_src  <= acc_src_d;
            reg_we   <= reg_we_d;
            illegal  <= illegal_d;
            halted   <= halted_d;
            flag_z   <= flag_z_d;
            flag_c   <= flag_c_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a variable-latency instruction memory model.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;
    logic       alu_z = 1'b0;
    logic       alu_c = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [3:0] alu_sel;
    logic       acc_we;
    logic       acc_src;
    logic       reg_we;
    logic [3:0] reg_addr;
    logic [7:0] imm;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic       illegal;

    logic [7:0] mem [256];
    int         lat = 1;
    int         cnt = 0;
    logic       rv_q = 1'b0;
    logic [7:0] rd_q = 8'h00;
    logic       inj_rv = 1'b0;
    logic [7:0] inj_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .alu_sel    (alu_sel),
        .acc_we     (acc_we),
        .acc_src    (acc_src),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .imm        (imm),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign mem_rvalid = rv_q | inj_rv;
    assign mem_rdata  = inj_rv ? inj_data : rd_q;

    // Memory answers lat cycles after it first sees mem_req, one-cycle rvalid pulse.
    always @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0;
            cnt  <= 0;
        end else begin
            rv_q <= 1'b0;
            if (mem_req && !rv_q) begin
                if (cnt + 1 >= lat) begin
                    rv_q <= 1'b1;
                    rd_q <= mem[mem_addr];
                    cnt  <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        inj_rv = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Wait for the next 0->1 edge of mem_req and check the address it presents.
    task automatic req_rise(input string tag, input logic [7:0] exp);
        logic prev;
        bit   hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            prev = mem_req;
            tick();
            hit = mem_req && !prev;
        end
        check(tag, hit ? 16'(mem_addr) : 16'hDEAD, 16'(exp));
    endtask

    task automatic branch_case(input string tag, input logic [7:0] br, input logic z,
                               input logic c, input logic [7:0] exp);
        clear_mem();
        mem[0] = 8'h21;
        mem[1] = br;
        mem[2] = 8'h20;
        alu_z  = z;
        alu_c  = c;
        do_reset();
        req_rise({tag, "_sub"}, 8'h00);
        req_rise({tag, "_op"}, 8'h01);
        req_rise({tag, "_arg"}, 8'h02);
        check({tag, "_flags"}, 16'({flag_z, flag_c}), 16'({z, c}));
        req_rise({tag, "_target"}, exp);
    endtask

    initial begin
        int hi;
        int reqs;
        bit stable;

        // LDI 5; MOVA R1; ADD R1 with single-cycle memory
        clear_mem();
        mem[0] = 8'h91; mem[1] = 8'h05; mem[2] = 8'h51; mem[3] = 8'h11;
        lat = 1;
        do_reset();
        check("rst_req",    16'(mem_req),  16'h0);
        check("rst_addr",   16'(mem_addr), 16'h00);
        check("rst_alusel", 16'(alu_sel),  16'h0);
        check("rst_strobe", 16'({acc_we, acc_src, reg_we, illegal, halted}), 16'h0);
        check("rst_imm",    16'(imm),      16'h00);
        check("rst_flags",  16'({flag_z, flag_c}), 16'h0);
        tick();
        check("f0_req", 16'({mem_req, mem_addr}), 16'h100);
        tick_n(5);
        check("ldi_exec", 16'({acc_we, acc_src, reg_we}), 16'b110);
        check("ldi_imm",  16'(imm), 16'h05);
        tick();
        check("ldi_done", 16'({acc_we, mem_req, mem_addr}), 16'h102);
        tick_n(3);
        check("mova_exec", 16'({reg_we, acc_we, reg_addr}), 16'h21);
        tick();
        check("mova_done", 16'({reg_we, mem_req, mem_addr}), 16'h103);
        tick_n(2);
        check("add_decode", 16'({acc_we, alu_sel, reg_addr}), 16'h011);
        tick();
        check("add_exec", 16'({acc_we, acc_src, alu_sel}), 16'h21);
        tick();
        check("add_done", 16'({acc_we, mem_req, mem_addr}), 16'h104);
        check("add_flags", 16'({flag_z, flag_c}), 16'h0);

        // Conditional and unconditional jumps after a flag-setting SUB
        branch_case("jz_t",  8'h60, 1'b1, 1'b0, 8'h20);
        branch_case("jz_n",  8'h60, 1'b0, 1'b0, 8'h03);
        branch_case("jc_t",  8'h70, 1'b0, 1'b1, 8'h20);
        branch_case("jc_n",  8'h70, 1'b0, 1'b0, 8'h03);
        branch_case("jmp",   8'h80, 1'b0, 1'b0, 8'h20);
        alu_z = 1'b0;
        alu_c = 1'b0;

        // Three-cycle memory: request held stable, spurious rvalid in DECODE ignored
        clear_mem();
        lat = 3;
        do_reset();
        req_rise("lat_first", 8'h00);
        hi = 1;
        stable = 1'b1;
        for (int i = 0; i < 20 && !mem_rvalid; i++) begin
            tick();
            if (mem_req) hi++;
            if (!mem_req || mem_addr !== 8'h00) stable = 1'b0;
        end
        check("lat_req_cycles", 16'(hi), 16'd4);
        check("lat_stable", 16'(stable), 16'h1);
        tick();
        check("lat_req_drop", 16'(mem_req), 16'h0);
        inj_data = 8'hA0;
        inj_rv   = 1'b1;
        tick();
        inj_rv = 1'b0;
        req_rise("lat_next", 8'h01);
        check("lat_not_halted", 16'(halted), 16'h0);
        lat = 1;

        // JMP at 0xFF fetches its operand from 0x00
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h80;
        do_reset();
        req_rise("jff_0", 8'h00);
        req_rise("jff_1", 8'h01);
        req_rise("jff_fe", 8'hFE);
        req_rise("jff_ff", 8'hFF);
        req_rise("jff_oper_wrap", 8'h00);
        req_rise("jff_target", 8'h80);

        // NOP at 0xFF wraps the PC to 0x00
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'hFF;
        do_reset();
        req_rise("nop_0", 8'h00);
        req_rise("nop_1", 8'h01);
        req_rise("nop_ff", 8'hFF);
        req_rise("nop_wrap", 8'h00);

        // Undefined opcode behaves as NOP with a one-cycle illegal pulse
        clear_mem();
        mem[0] = 8'hE0;
        do_reset();
        req_rise("ill_fetch", 8'h00);
        tick_n(3);
        check("ill_exec", 16'({illegal, acc_we, reg_we, acc_src}), 16'b1000);
        tick();
        check("ill_after", 16'({illegal, mem_req, mem_addr}), 16'h101);

        // HALT stops all fetching until reset
        clear_mem();
        mem[0] = 8'hA0;
        do_reset();
        req_rise("halt_fetch", 8'h00);
        tick_n(4);
        check("halt_set", 16'({halted, mem_req}), 16'b10);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) reqs++;
        end
        check("halt_no_req", 16'(reqs), 16'd0);
        check("halt_held", 16'(halted), 16'h1);

        // Reset during an operand wait, then a stale rvalid before the new request
        clear_mem();
        mem[0] = 8'h21; mem[1] = 8'h91; mem[2] = 8'h33;
        alu_z = 1'b1;
        alu_c = 1'b1;
        lat = 3;
        do_reset();
        req_rise("ro_sub", 8'h00);
        req_rise("ro_ldi", 8'h01);
        req_rise("ro_oper", 8'h02);
        tick();
        check("ro_flags_pre", 16'({flag_z, flag_c}), 16'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ro_rst_req", 16'({mem_req, mem_addr}), 16'h000);
        check("ro_rst_dec", 16'({alu_sel, reg_addr}), 16'h00);
        check("ro_rst_misc", 16'({imm, flag_z, flag_c, halted, illegal}), 16'h0);
        check("ro_rst_strobe", 16'({acc_we, acc_src, reg_we}), 16'h0);
        inj_data = 8'hA0;
        inj_rv   = 1'b1;
        tick();
        inj_rv = 1'b0;
        check("ro_stale_ignored", 16'({mem_req, mem_addr}), 16'h100);
        req_rise("ro_refetch_ldi", 8'h01);
        check("ro_no_halt", 16'(halted), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
